// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, fixed programmable access
// latency, registered completion held until the core takes it.
module dmem_responder #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              busy_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              write_reg, write_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;

    logic              in_range;
    logic              commit;
    logic              rsp_done;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] mem [DEPTH];

    // Full-width compare so an address equal to DEPTH never aliases word 0.
    assign in_range = ({1'b0, addr_reg} < (ADDR_W + 1)'(DEPTH));
    assign idx      = addr_reg[IDX_W-1:0];
    assign commit   = (state_reg == S_WAIT) && (cnt_reg == 4'd0);
    assign rsp_done = (state_reg == S_RESP) && rsp_ready_i;

    assign req_ready_o = (state_reg == S_IDLE);
    assign rsp_valid_o = (state_reg == S_RESP);
    assign busy_o      = (state_reg != S_IDLE);
    assign rsp_rdata_o = rdata_reg;
    assign rsp_err_o   = err_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        write_next = write_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_next = S_WAIT;
                    cnt_next   = 4'(WAIT_CYCLES);
                    write_next = req_write_i;
                    addr_next  = req_addr_i;
                    wdata_next = req_wdata_i;
                end
            end
            S_WAIT: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            write_reg <= write_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            if (commit) begin
                rdata_reg <= (in_range && !write_reg) ? mem[idx] : '0;
                err_reg   <= !in_range;
            end else if (rsp_done) begin
                rdata_reg <= '0;
                err_reg   <= 1'b0;
            end
        end
    end

    // Array has no reset; a reset edge must never let a pending store land.
    always_ff @(posedge clk_i) begin
        if (rst_ni && commit && in_range && write_reg) begin
            mem[idx] <= wdata_reg;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 has 2 wait cycles and 200 words,
// instance 1 has zero wait cycles and 256 words.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [7:0]  req_addr  [2];
    logic [63:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [63:0] model_mem [2][256];
    bit          written   [2][256];

    typedef struct {
        int          d;
        bit          w;
        logic [7:0]  a;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        bit          exp_er;
    } vec_t;

    dmem_responder #(.DATA_W(64), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_write_i(req_write[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]), .busy_o(busy[0])
    );

    dmem_responder #(.DATA_W(64), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_write_i(req_write[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]), .busy_o(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int depth_of(int d);
        return (d == 0) ? 200 : 256;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Present a request and return just after the edge that accepts it.
    task automatic send(int d, bit w, logic [7:0] a, logic [63:0] wd);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        n = 0;
        while (!req_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 64'(req_ready[d]), 64'd1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
    endtask

    // Count edges from acceptance until the response is visible.
    task automatic get_rsp(int d, output int lat, output logic [63:0] rd, output logic er);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rsp_valid[d] && lat < 64);
        check("rsp_arrives", 64'(rsp_valid[d]), 64'd1);
        rd = rsp_rdata[d];
        er = rsp_err[d];
    endtask

    task automatic do_txn(int d, bit w, logic [7:0] a, logic [63:0] wd,
                          logic [63:0] exp_rd, bit exp_er, int stall);
        int          lat;
        logic [63:0] rd;
        logic        er;
        rsp_ready[d] = (stall == 0);
        send(d, w, a, wd);
        get_rsp(d, lat, rd, er);
        check("latency", 64'(lat), 64'(wait_of(d) + 1));
        check("rdata", rd, exp_rd);
        check("err", 64'(er), 64'(exp_er));
        check("busy_in_resp", 64'(busy[d]), 64'd1);
        check("ready_in_resp", 64'(req_ready[d]), 64'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", 64'(rsp_valid[d]), 64'd1);
            check("stall_rdata", rsp_rdata[d], exp_rd);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_valid", 64'(rsp_valid[d]), 64'd0);
        check("post_hs_rdata", rsp_rdata[d], 64'd0);
        check("post_hs_err", 64'(rsp_err[d]), 64'd0);
        if (w && int'(a) < depth_of(d)) begin
            model_mem[d][a] = wd;
            written[d][a]   = 1'b1;
        end
        $display("[TB] dut%0d %s addr=%0d wdata=%h -> rdata=%h err=%0d lat=%0d stall=%0d",
                 d, w ? "ST" : "LD", a, wd, rd, er, lat, stall);
    endtask

    initial begin
        vec_t        vecs[$];
        int          lat;
        logic [63:0] rd;
        logic        er;
        int          acc[$];
        int          n;

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b1;
        end

        vecs.push_back('{0, 1'b1, 8'd0,   64'hA5A5_0000_0000_0001, 64'd0, 1'b0});
        vecs.push_back('{0, 1'b1, 8'h10,  64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0});
        vecs.push_back('{0, 1'b0, 8'h10,  64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0});
        vecs.push_back('{0, 1'b1, 8'd200, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1});
        vecs.push_back('{0, 1'b0, 8'd0,   64'd0, 64'hA5A5_0000_0000_0001, 1'b0});
        vecs.push_back('{0, 1'b0, 8'd255, 64'd0, 64'd0, 1'b1});
        vecs.push_back('{0, 1'b1, 8'd199, 64'h0000_0000_0000_1234, 64'd0, 1'b0});
        vecs.push_back('{0, 1'b0, 8'd199, 64'd0, 64'h0000_0000_0000_1234, 1'b0});
        vecs.push_back('{1, 1'b1, 8'd5,   64'h0123_4567_89AB_CDEF, 64'd0, 1'b0});
        vecs.push_back('{1, 1'b0, 8'd5,   64'd0, 64'h0123_4567_89AB_CDEF, 1'b0});
        vecs.push_back('{1, 1'b1, 8'd255, 64'hCAFE_F00D_0000_00FF, 64'd0, 1'b0});
        vecs.push_back('{1, 1'b0, 8'd255, 64'd0, 64'hCAFE_F00D_0000_00FF, 1'b0});

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_req_ready", 64'(req_ready[d]), 64'd1);
            check("reset_rsp_valid", 64'(rsp_valid[d]), 64'd0);
            check("reset_busy", 64'(busy[d]), 64'd0);
            check("reset_rdata", rsp_rdata[d], 64'd0);
            check("reset_err", 64'(rsp_err[d]), 64'd0);
        end

        foreach (vecs[i])
            do_txn(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_er, 0);

        // Backpressure: response held while a second request waits.
        rsp_ready[0] = 1'b0;
        send(0, 1'b0, 8'h10, 64'd0);
        get_rsp(0, lat, rd, er);
        check("bp_rdata", rd, 64'hDEAD_BEEF_0123_4567);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 8'h10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid[0]), 64'd1);
            check("bp_hold_rdata", rsp_rdata[0], 64'hDEAD_BEEF_0123_4567);
            check("bp_req_ready", 64'(req_ready[0]), 64'd0);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_ready", 64'(req_ready[0]), 64'd1);
        check("bp_idle_busy", 64'(busy[0]), 64'd0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        check("bp_second_accepted", 64'(busy[0]), 64'd1);
        get_rsp(0, lat, rd, er);
        check("bp_second_lat", 64'(lat), 64'd3);
        check("bp_second_rdata", rd, 64'hDEAD_BEEF_0123_4567);
        @(posedge clk);
        #1;
        $display("[TB] dut0 backpressure sequence done, second rdata=%h", rd);

        // Zero-latency back-to-back loads: one acceptance every 3 cycles.
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 8'd5;
        for (int i = 0; i < 14; i++) begin
            if (req_ready[1]) acc.push_back(cyc);
            if (rsp_valid[1]) check("b2b_rdata", rsp_rdata[1], model_mem[1][5]);
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        check("b2b_accept_count", 64'(acc.size() >= 4), 64'd1);
        for (int i = 1; i < acc.size(); i++)
            check("b2b_spacing", 64'(acc[i] - acc[i-1]), 64'd3);
        n = 0;
        while (busy[1] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drain", 64'(busy[1]), 64'd0);
        $display("[TB] dut1 back-to-back: %0d acceptances", acc.size());

        // Reset during WAIT aborts a pending store.
        do_txn(0, 1'b1, 8'h20, 64'h5, 64'd0, 1'b0, 0);
        send(0, 1'b1, 8'h20, 64'h1);
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1 rst_n[0] = 1'b1;
        check("midrst_valid", 64'(rsp_valid[0]), 64'd0);
        check("midrst_busy", 64'(busy[0]), 64'd0);
        check("midrst_ready", 64'(req_ready[0]), 64'd1);
        $display("[TB] dut0 reset during WAIT");
        do_txn(0, 1'b0, 8'h20, 64'd0, 64'h5, 1'b0, 0);

        // Reset during RESP drops the response but keeps the committed store.
        rsp_ready[0] = 1'b0;
        send(0, 1'b1, 8'h21, 64'h7);
        get_rsp(0, lat, rd, er);
        @(negedge clk);
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1 rst_n[0] = 1'b1;
        rsp_ready[0] = 1'b1;
        check("resprst_valid", 64'(rsp_valid[0]), 64'd0);
        check("resprst_rdata", rsp_rdata[0], 64'd0);
        model_mem[0][8'h21] = 64'h7;
        written[0][8'h21]   = 1'b1;
        $display("[TB] dut0 reset during RESP");
        do_txn(0, 1'b0, 8'h21, 64'd0, 64'h7, 1'b0, 0);

        // Randomized traffic against the array model.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                logic [7:0]  a;
                bit          w;
                logic [63:0] wd;
                logic [63:0] exp_rd;
                bit          exp_er;
                int          stall;
                a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255))
                                                 : 8'($urandom_range(0, 31));
                w  = ($urandom_range(0, 1) == 1);
                if (int'(a) < depth_of(d) && !written[d][a]) w = 1'b1;
                wd = {$urandom, $urandom};
                stall  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                exp_er = (int'(a) >= depth_of(d));
                exp_rd = (!exp_er && !w) ? model_mem[d][a] : 64'd0;
                do_txn(d, w, a, wd, exp_rd, exp_er, stall);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
